mole_spawner: RTL and testbench

- Consumer end of the random-number request interface (next / max_num / rand_num / rand_valid).
- Issues a single-cycle next pulse, captures the returned hole index and lights one mole for a fixed number of ticks.
- Scores whack hits and misses, then requests the next hole.
- Sits between the random generator and the score, display and LED logic.

---
 rtl/mole_pkg.sv | 19 +
 rtl/mole_spawner.sv | 190 +++++++++++++++++++
 tb/tb_mole_spawner.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mole_pkg.sv
// mole_pkg: state encoding and hole-index helpers shared by the mole game blocks.
package mole_pkg;

    localparam int HOLE_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        SHOW,
        GAP
    } state_t;

    // The "no hole" marker is the hole count itself, one past the last legal index.
    function automatic logic [HOLE_W:0] no_hole(input int num_holes);
        return (HOLE_W + 1)'(num_holes);
    endfunction

endpackage

// File: rtl/mole_spawner.sv
// mole_spawner: requests a random hole, lights one mole for a fixed number of ticks,
// then scores the player's presses as hit, miss or wrong before asking for the next hole.
module mole_spawner
    import mole_pkg::*;
#(
    parameter int NUM_HOLES    = 10,
    parameter int SHOW_TICKS   = 8,
    parameter int GAP_TICKS    = 2,
    parameter int RAND_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 tick,
    input  logic [NUM_HOLES-1:0] hit_btn,
    output logic                 rand_next,
    output logic [HOLE_W-1:0]    rand_max,
    input  logic [HOLE_W-1:0]    rand_num,
    input  logic                 rand_valid,
    output logic [NUM_HOLES-1:0] mole,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 wrong_pulse,
    output logic                 active
);

    localparam int CNT_MAX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TO_W    = (RAND_TIMEOUT > 1) ? $clog2(RAND_TIMEOUT) : 1;

    localparam logic [HOLE_W:0]    NO_HOLE   = no_hole(NUM_HOLES);
    localparam logic [CNT_W-1:0]   SHOW_LAST = CNT_W'(SHOW_TICKS - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(RAND_TIMEOUT - 1);
    localparam logic [TO_W-1:0]    TO_ONE    = TO_W'(1);
    localparam logic [NUM_HOLES-1:0] MOLE_ONE = NUM_HOLES'(1);

    // Range-checks the generator value and steps past a repeat of the previous hole.
    function automatic logic [HOLE_W:0] pick_hole(input logic [HOLE_W-1:0] r,
                                                  input logic [HOLE_W:0]   last);
        logic [HOLE_W:0] w_r;
        logic [HOLE_W:0] w_inc;
        w_r   = {1'b0, r};
        w_inc = w_r + {{HOLE_W{1'b0}}, 1'b1};
        if (w_inc == NO_HOLE) begin
            w_inc = '0;
        end
        if (w_r >= NO_HOLE) begin
            return NO_HOLE;
        end
        if (w_r == last) begin
            return w_inc;
        end
        return w_r;
    endfunction

    state_t                 r_state,     w_state;
    logic [NUM_HOLES-1:0]   r_mole,      w_mole;
    logic [HOLE_W:0]        r_last_hole, w_last_hole;
    logic [CNT_W-1:0]       r_tick_cnt,  w_tick_cnt;
    logic [TO_W-1:0]        r_to_cnt,    w_to_cnt;
    logic                   r_rand_next, w_rand_next;
    logic                   r_hit,       w_hit;
    logic                   r_miss,      w_miss;
    logic                   r_wrong,     w_wrong;
    logic                   r_active;
    logic [HOLE_W:0]        w_pick;
    logic                   w_pressed_lit;
    logic                   w_pressed_other;

    assign w_pick          = pick_hole(rand_num, r_last_hole);
    assign w_pressed_lit   = |(hit_btn & r_mole);
    assign w_pressed_other = |(hit_btn & ~r_mole);

    always_comb begin
        w_state     = r_state;
        w_mole      = r_mole;
        w_last_hole = r_last_hole;
        w_tick_cnt  = r_tick_cnt;
        w_to_cnt    = r_to_cnt;
        w_rand_next = 1'b0;
        w_hit       = 1'b0;
        w_miss      = 1'b0;
        w_wrong     = 1'b0;
        if (!enable) begin
            w_state = IDLE;
            w_mole  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state     = REQ;
                    w_rand_next = 1'b1;
                end
                REQ: begin
                    w_to_cnt = '0;
                    w_state  = WAIT;
                end
                WAIT: begin
                    if (rand_valid) begin
                        if (w_pick == NO_HOLE) begin
                            w_state     = REQ;
                            w_rand_next = 1'b1;
                        end else begin
                            w_mole      = MOLE_ONE << w_pick;
                            w_last_hole = w_pick;
                            w_tick_cnt  = '0;
                            w_state     = SHOW;
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        w_state     = REQ;
                        w_rand_next = 1'b1;
                    end else begin
                        w_to_cnt = r_to_cnt + TO_ONE;
                    end
                end
                // A press on the lit hole wins over both a stray press and expiry.
                SHOW: begin
                    if (w_pressed_lit) begin
                        w_hit      = 1'b1;
                        w_mole     = '0;
                        w_tick_cnt = '0;
                        w_state    = GAP;
                    end else begin
                        w_wrong = w_pressed_other;
                        if (tick) begin
                            if (r_tick_cnt == SHOW_LAST) begin
                                w_miss     = 1'b1;
                                w_mole     = '0;
                                w_tick_cnt = '0;
                                w_state    = GAP;
                            end else begin
                                w_tick_cnt = r_tick_cnt + CNT_ONE;
                            end
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (r_tick_cnt == GAP_LAST) begin
                            w_state     = REQ;
                            w_rand_next = 1'b1;
                        end else begin
                            w_tick_cnt = r_tick_cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    w_state = IDLE;
                    w_mole  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_mole      <= '0;
            r_last_hole <= NO_HOLE;
            r_tick_cnt  <= '0;
            r_to_cnt    <= '0;
            r_rand_next <= 1'b0;
            r_hit       <= 1'b0;
            r_miss      <= 1'b0;
            r_wrong     <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_mole      <= w_mole;
            r_last_hole <= w_last_hole;
            r_tick_cnt  <= w_tick_cnt;
            r_to_cnt    <= w_to_cnt;
            r_rand_next <= w_rand_next;
            r_hit       <= w_hit;
            r_miss      <= w_miss;
            r_wrong     <= w_wrong;
            r_active    <= (w_state != IDLE);
        end
    end

    assign rand_next   = r_rand_next;
    assign rand_max    = HOLE_W'(NUM_HOLES - 1);
    assign mole        = r_mole;
    assign hit_pulse   = r_hit;
    assign miss_pulse  = r_miss;
    assign wrong_pulse = r_wrong;
    assign active      = r_active;

endmodule

// File: tb/tb_mole_spawner.sv
// Randomised bench for mole_spawner: a game-level model predicts every visible output change,
// and a separate monitor pops those predictions whenever the DUT shows a pulse or a change.
module tb_mole_spawner;

    localparam int NH = 10;
    localparam int ST = 8;
    localparam int GT = 2;
    localparam int RT = 4;

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic          enable     = 1'b0;
    logic          tick       = 1'b0;
    logic [NH-1:0] hit_btn    = '0;
    logic [3:0]    rand_num   = '0;
    logic          rand_valid = 1'b0;
    logic          rand_next;
    logic [3:0]    rand_max;
    logic [NH-1:0] mole;
    logic          hit_pulse;
    logic          miss_pulse;
    logic          wrong_pulse;
    logic          active;

    mole_spawner #(
        .NUM_HOLES   (NH),
        .SHOW_TICKS  (ST),
        .GAP_TICKS   (GT),
        .RAND_TIMEOUT(RT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .tick       (tick),
        .hit_btn    (hit_btn),
        .rand_next  (rand_next),
        .rand_max   (rand_max),
        .rand_num   (rand_num),
        .rand_valid (rand_valid),
        .mole       (mole),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .wrong_pulse(wrong_pulse),
        .active     (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [NH-1:0] mole;
        logic          nxt;
        logic          hit;
        logic          miss;
        logic          wrong;
        logic          act;
    } snap_t;

    typedef enum {M_OFF, M_ASK, M_LISTEN, M_UP, M_DARK} mphase_t;

    int      cyc     = 0;
    int      checks  = 0;
    int      errors  = 0;
    bit      inReset = 1'b1;
    bit      done    = 1'b0;
    snap_t   expQ[$];

    mphase_t mPhase;
    int      mLast;
    int      mHole;
    int      mTicks;
    int      mAge;
    snap_t   mOut;
    int      stubWait;
    int      enOffLeft;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input snap_t e, input snap_t d);
        checks++;
        if (d.mole !== e.mole || d.nxt !== e.nxt || d.hit !== e.hit ||
            d.miss !== e.miss || d.wrong !== e.wrong || d.act !== e.act) begin
            errors++;
            $display("[TB] FAIL event@%0d got mole=%h next=%b hit=%b miss=%b wrong=%b act=%b want mole=%h next=%b hit=%b miss=%b wrong=%b act=%b",
                     e.cyc, d.mole, d.nxt, d.hit, d.miss, d.wrong, d.act,
                     e.mole, e.nxt, e.hit, e.miss, e.wrong, e.act);
        end
    endtask

    task automatic modelReset();
        mPhase    = M_OFF;
        mLast     = NH;
        mHole     = 0;
        mTicks    = 0;
        mAge      = 0;
        mOut      = '{cyc: 0, mole: '0, nxt: 1'b0, hit: 1'b0, miss: 1'b0, wrong: 1'b0, act: 1'b0};
        stubWait  = -1;
        enOffLeft = 0;
        expQ.delete();
    endtask

    // Game rules applied to one cycle of inputs; any visible change becomes an expected event.
    task automatic modelStep(input bit en, input bit tk, input logic [NH-1:0] btn,
                             input bit rv, input int rn);
        snap_t n;
        n       = mOut;
        n.cyc   = cyc + 1;
        n.nxt   = 1'b0;
        n.hit   = 1'b0;
        n.miss  = 1'b0;
        n.wrong = 1'b0;
        if (!en) begin
            mPhase = M_OFF;
            n.mole = '0;
        end else begin
            case (mPhase)
                M_OFF: begin
                    mPhase = M_ASK;
                    n.nxt  = 1'b1;
                end
                M_ASK: begin
                    mPhase = M_LISTEN;
                    mAge   = 0;
                end
                M_LISTEN: begin
                    if (rv) begin
                        if (rn >= NH) begin
                            mPhase = M_ASK;
                            n.nxt  = 1'b1;
                        end else begin
                            mHole        = (rn == mLast) ? (rn + 1) % NH : rn;
                            mLast        = mHole;
                            n.mole       = '0;
                            n.mole[mHole] = 1'b1;
                            mTicks       = 0;
                            mPhase       = M_UP;
                        end
                    end else if (mAge + 1 >= RT) begin
                        mPhase = M_ASK;
                        n.nxt  = 1'b1;
                    end else begin
                        mAge++;
                    end
                end
                M_UP: begin
                    if (btn[mHole]) begin
                        n.hit  = 1'b1;
                        n.mole = '0;
                        mTicks = 0;
                        mPhase = M_DARK;
                    end else begin
                        if (btn != '0) n.wrong = 1'b1;
                        if (tk) begin
                            mTicks++;
                            if (mTicks == ST) begin
                                n.miss = 1'b1;
                                n.mole = '0;
                                mTicks = 0;
                                mPhase = M_DARK;
                            end
                        end
                    end
                end
                M_DARK: begin
                    if (tk) begin
                        mTicks++;
                        if (mTicks == GT) begin
                            mPhase = M_ASK;
                            n.nxt  = 1'b1;
                        end
                    end
                end
                default: mPhase = M_OFF;
            endcase
        end
        n.act = (mPhase != M_OFF);
        if (n.nxt || n.hit || n.miss || n.wrong || n.mole != mOut.mole || n.act != mOut.act)
            expQ.push_back(n);
        mOut = n;
    endtask

    task automatic applyStimulus(input int nCycles);
        bit            en;
        bit            tk;
        bit            rv;
        int            rn;
        int            r;
        logic [NH-1:0] btn;
        for (int i = 0; i < nCycles; i++) begin
            @(negedge clk);
            rv = 1'b0;
            rn = $urandom_range(0, 15);
            if (mOut.nxt) begin
                stubWait = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 5) : $urandom_range(0, 2);
            end else if (stubWait == 0) begin
                rv       = 1'b1;
                stubWait = -1;
                case ($urandom_range(0, 3))
                    0:       rn = $urandom_range(NH, 15);
                    1:       rn = (mLast < NH) ? mLast : 0;
                    default: rn = $urandom_range(0, NH - 1);
                endcase
            end else if (stubWait > 0) begin
                stubWait--;
            end else if ($urandom_range(0, 19) == 0) begin
                rv = 1'b1;
            end
            if (enOffLeft > 0) begin
                en = 1'b0;
                enOffLeft--;
            end else if ($urandom_range(0, 149) == 0) begin
                en        = 1'b0;
                enOffLeft = $urandom_range(0, 3);
            end else begin
                en = 1'b1;
            end
            tk  = ($urandom_range(0, 2) == 0);
            btn = '0;
            r   = $urandom_range(0, 39);
            if (mOut.mole != '0) begin
                if (r == 0) begin
                    btn = mOut.mole;
                    if ($urandom_range(0, 2) == 0) btn |= NH'(1) << $urandom_range(0, NH - 1);
                end else if (r < 3) begin
                    btn = NH'($urandom);
                end
            end else if (r < 3) begin
                btn = NH'($urandom);
            end
            enable     = en;
            tick       = tk;
            hit_btn    = btn;
            rand_valid = rv;
            rand_num   = 4'(rn);
            modelStep(en, tk, btn, rv, rn);
        end
    endtask

    // Monitor: pops a prediction only when the DUT shows a pulse or an output change.
    initial begin
        snap_t cur;
        snap_t prev;
        snap_t e;
        bit    pres;
        prev = '{cyc: 0, mole: '0, nxt: 1'b0, hit: 1'b0, miss: 1'b0, wrong: 1'b0, act: 1'b0};
        forever begin
            @(posedge clk);
            #1;
            cur = '{cyc: cyc, mole: mole, nxt: rand_next, hit: hit_pulse, miss: miss_pulse,
                    wrong: wrong_pulse, act: active};
            if (!inReset && !done) begin
                while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
                    e = expQ.pop_front();
                    checks++;
                    errors++;
                    $display("[TB] FAIL missing_event@%0d got no output change want mole=%h next=%b hit=%b miss=%b wrong=%b act=%b",
                             e.cyc, e.mole, e.nxt, e.hit, e.miss, e.wrong, e.act);
                end
                pres = cur.nxt || cur.hit || cur.miss || cur.wrong ||
                       cur.mole != prev.mole || cur.act != prev.act;
                if (pres) begin
                    if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
                        e = expQ.pop_front();
                        checkOutput(e, cur);
                    end else begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_output@%0d got mole=%h next=%b hit=%b miss=%b wrong=%b act=%b want no change",
                                 cyc, cur.mole, cur.nxt, cur.hit, cur.miss, cur.wrong, cur.act);
                    end
                end
            end
            prev = cur;
        end
    end

    task automatic midRunReset();
        int guard;
        guard = 0;
        while (mPhase != M_UP && guard < 300) begin
            applyStimulus(1);
            guard++;
        end
        if (mPhase != M_UP) begin
            checks++;
            errors++;
            $display("[TB] FAIL show_wait got no lit mole within 300 cycles want a lit mole");
        end
        #3;
        inReset = 1'b1;
        reset_n = 1'b0;
        expQ.delete();
        #1;
        checkValue("async_reset_mole", 32'(mole), 32'd0);
        checkValue("async_reset_active", 32'(active), 32'd0);
        checkValue("async_reset_next", 32'(rand_next), 32'd0);
        @(negedge clk);
        @(negedge clk);
        enable     = 1'b0;
        tick       = 1'b0;
        hit_btn    = '0;
        rand_valid = 1'b0;
        modelReset();
        reset_n    = 1'b1;
        inReset    = 1'b0;
    endtask

    initial begin
        modelReset();
        repeat (3) @(negedge clk);
        checkValue("reset_mole", 32'(mole), 32'd0);
        checkValue("reset_next", 32'(rand_next), 32'd0);
        checkValue("reset_active", 32'(active), 32'd0);
        checkValue("reset_hit", 32'(hit_pulse), 32'd0);
        checkValue("reset_miss", 32'(miss_pulse), 32'd0);
        checkValue("reset_wrong", 32'(wrong_pulse), 32'd0);
        checkValue("rand_max", 32'(rand_max), 32'(NH - 1));
        reset_n = 1'b1;
        inReset = 1'b0;
        applyStimulus(3000);
        midRunReset();
        applyStimulus(3000);
        @(posedge clk);
        #2;
        done = 1'b1;
        while (expQ.size() > 0) begin
            snap_t e;
            e = expQ.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL leftover_event@%0d got no output change want mole=%h next=%b act=%b",
                     e.cyc, e.mole, e.nxt, e.act);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
